key_filter: RTL



---
 rtl/key_filter.sv | 116 +++++++++++
 1 files changed

// File: rtl/key_filter.sv
// Push-button debouncer: two-flop synchronizer feeding a four-state filter FSM.
// Emits a clean pressed level plus registered one-cycle press/release pulses.
//
// state        | meaning
// -------------+------------------------------------------------------
// IDLE         | key released and stable, waiting for a low sample
// PRESS_FILT   | low seen, counting consecutive low samples to confirm
// PRESSED      | key pressed and stable, waiting for a high sample
// RELEASE_FILT | high seen, counting consecutive high samples to confirm
module key_filter #(
  parameter int unsigned CNT_MAX = 999_999,
  parameter int unsigned CNT_W   = 20
) (
  input  logic sys_clk,
  input  logic sys_rest_n,
  input  logic key_in,
  output logic key_state,
  output logic key_flag,
  output logic key_release
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_FILT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_FILT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(CNT_MAX);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             s1, key_s;
  logic             key_state_nxt, key_flag_nxt, key_release_nxt;

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge sys_clk or negedge sys_rest_n) begin
    if (!sys_rest_n) begin
      s1    <= 1'b1;
      key_s <= 1'b1;
    end else begin
      s1    <= key_in;
      key_s <= s1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rest_n) begin
    if (!sys_rest_n) begin
      state       <= IDLE;
      cnt         <= '0;
      key_state   <= 1'b0;
      key_flag    <= 1'b0;
      key_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      key_state   <= key_state_nxt;
      key_flag    <= key_flag_nxt;
      key_release <= key_release_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    key_state_nxt   = key_state;
    key_flag_nxt    = 1'b0;
    key_release_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!key_s) begin
          state_nxt = PRESS_FILT;
          cnt_nxt   = '0;
        end
      end
      PRESS_FILT: begin
        if (key_s) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_TOP) begin
          state_nxt     = PRESSED;
          cnt_nxt       = '0;
          key_state_nxt = 1'b1;
          key_flag_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_nxt = RELEASE_FILT;
          cnt_nxt   = '0;
        end
      end
      RELEASE_FILT: begin
        if (!key_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt == CNT_TOP) begin
          state_nxt       = IDLE;
          cnt_nxt         = '0;
          key_state_nxt   = 1'b0;
          key_release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt     = IDLE;
        cnt_nxt       = '0;
        key_state_nxt = 1'b0;
      end
    endcase
  end

endmodule
